// File: rtl/mem_lsu.sv
// Load/store unit bridging a single-request CPU port to a word-wide async-read data memory.
// Optional build macro MISALIGN_TRAP_EN: report misaligned H/HU/SH and W/SW as errors.
module mem_lsu #(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRW,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, old_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic        accept, illegal;
  logic [31:0] shifted, load_data, store_word;
  logic [15:0] half;

  assign accept = req_valid && (state_q == StIdle);

  always_comb begin
    illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_we && req_funct3[2]);
`ifdef MISALIGN_TRAP_EN
    illegal = illegal
            || ((req_funct3[1:0] == 2'b01) && req_addr[0])
            || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (illegal)                                 state_d = StResp;
          else if (req_we && req_funct3[1:0] == 2'b10) state_d = StWr;
          else                                         state_d = StRd;
        end
      end
      StRd:    state_d = we_q ? StWr : StResp;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shifted   = mem_rdata >> {addr_q[1:0], 3'b000};
    half      = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (f3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{half[15]}}, half};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, half};
      default: load_data = mem_rdata;
    endcase
  end

  // Sub-word stores overlay the lane onto the word captured during RD.
  always_comb begin
    store_word = old_q;
    case (f3_q[1:0])
      2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: store_word = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      old_q        <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      if (accept) begin
        we_q       <= req_we;
        f3_q       <= req_funct3;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        resp_err_q <= illegal;
      end
      if (state_q == StRd) begin
        if (we_q) old_q        <= mem_rdata;
        else      resp_rdata_q <= load_data;
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign MemRW      = (state_q == StWr);
  assign mem_addr   = ((state_q == StRd) || (state_q == StWr)) ?
                      ((addr_q - MEM_BASE) & 32'hFFFF_FFFC) : 32'h0;
  assign mem_wdata  = (state_q == StWr) ? store_word : 32'h0;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: driver pushes expected responses/writes, monitor pops and compares.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, MemRW;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_init;
  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .MemRW(MemRW),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h5566_7788;
      mem[1] <= 32'hCAFE_F00D;
    end else if (MemRW) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  typedef struct {logic [31:0] rdata; logic err; int lat; int acc;} resp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; int lat; int acc;} wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_resp = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every response and every memory write against the queues.
  always @(negedge clk) begin
    if (!rst && !mem_init) begin
      check("addr_align", {30'h0, mem_addr[1:0]}, 32'h0);
      if (!resp_valid) begin
        check("rdata_quiet", resp_rdata, 32'h0);
        check("err_quiet", {31'h0, resp_err}, 32'h0);
      end else begin
        last_resp = cyc;
        if (resp_q.size() == 0) begin
          check("unexpected_resp", 32'h1, 32'h0);
        end else begin
          resp_t e;
          e = resp_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
          check("resp_latency", cyc - e.acc, e.lat);
        end
      end
      if (MemRW) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 32'h1, 32'h0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", mem_addr, w.addr);
          check("wr_data", mem_wdata, w.data);
          check("wr_latency", cyc - w.acc, w.lat);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance with req_valid still high.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int lat, input int wlat,
                       input logic [31:0] exp_wdata, input bit expect_resp, input bit chk_b2b);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      check("accept_timeout", 32'h1, 32'h0);
    end else begin
      if (chk_b2b) check("b2b_accept_cycle", cyc, last_resp + 1);
      if (expect_resp) begin
        resp_q.push_back('{exp_rdata, exp_err, lat, cyc});
        if (wlat > 0) wr_q.push_back('{addr & 32'hFFFF_FFFC, exp_wdata, wlat, cyc});
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_wait();
    req_valid = 1'b0;
    for (int i = 0; i < 30 && (resp_q.size() != 0 || !req_ready); i++) @(negedge clk);
    check("drain_resp_queue", resp_q.size(), 0);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
    issue(1'b0, f3, addr, 32'h0, exp, 1'b0, 2, 0, 32'h0, 1'b1, 1'b0);
    idle_wait();
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [31:0] exp_word);
    int sub;
    sub = (f3 == 3'b010) ? 0 : 1;
    issue(1'b1, f3, addr, wd, 32'h0, 1'b0, 2 + sub, 1 + sub, exp_word, 1'b1, 1'b0);
    idle_wait();
  endtask

  initial begin
    mem_init   = 1'b1;
    rst        = 1'b1;
    req_valid  = 1'b1;  // must be ignored while in reset
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'h0, req_ready}, 32'h1);
    check("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("reset_memrw", {31'h0, MemRW}, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    mem_init  = 1'b0;
    rst       = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);

    st(3'b010, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    ld(3'b010, 32'h10, 32'hDEAD_BEEF);
    st(3'b010, 32'h10, 32'h1122_3344, 32'h1122_3344);
    st(3'b000, 32'h13, 32'h0000_00A5, 32'hA522_3344);
    ld(3'b000, 32'h13, 32'hFFFF_FFA5);
    ld(3'b100, 32'h13, 32'h0000_00A5);
    st(3'b001, 32'h22, 32'h0000_8001, 32'h8001_0000);
    ld(3'b001, 32'h22, 32'hFFFF_8001);
    ld(3'b101, 32'h22, 32'h0000_8001);
    ld(3'b000, 32'h23, 32'hFFFF_FF80);
    ld(3'b100, 32'h22, 32'h0000_0001);

`ifdef MISALIGN_TRAP_EN
    issue(1'b0, 3'b010, 32'h06, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 1'b1, 1'b0);
    idle_wait();
`else
    ld(3'b010, 32'h06, 32'hCAFE_F00D);
`endif

    // Illegal load width and illegal store width: error after one cycle, no write.
    issue(1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 1'b1, 1'b0);
    idle_wait();
    issue(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0, 32'h0, 1'b1, 1'b0);
    idle_wait();

    // Reset while the SB sits in RD: no write, no response.
    issue(1'b1, 3'b000, 32'h01, 32'h0000_00FF, 32'h0, 1'b0, 0, 0, 32'h0, 1'b0, 1'b0);
    rst       = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("post_reset_ready", {31'h0, req_ready}, 32'h1);
    check("post_reset_resp", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    ld(3'b010, 32'h00, 32'h5566_7788);

    // Back-to-back with req_valid held high throughout.
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hA522_3344, 1'b0, 2, 0, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 1'b1, 1'b1);
    issue(1'b1, 3'b010, 32'h08, 32'h1234_5678, 32'h0, 1'b0, 2, 1, 32'h1234_5678, 1'b1, 1'b1);
    idle_wait();
    ld(3'b010, 32'h08, 32'h1234_5678);

    repeat (3) @(negedge clk);
    check("wr_queue_empty", wr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter: MEM_BASE, 32'h0000_0000, byte base subtracted from the latched request address to form mem_addr.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on posedge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_valid  input  1  CPU request present.
REQ-005 SHALL have port: req_ready  output  1  unit idle; request accepted when req_valid && req_ready.
REQ-006 SHALL have port: req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port: req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port: req_addr  input  32  byte address.
REQ-009 SHALL have port: req_wdata  input  32  store data, low-aligned.
REQ-010 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 SHALL have port: resp_err  output  1  misaligned or illegal request, valid with resp_valid.
REQ-013 SHALL have port: MemRW  output  1  data-memory write enable, 1=write.
REQ-014 SHALL have port: mem_addr  output  32  data-memory byte address, bits [1:0] always 00.
REQ-015 SHALL have port: mem_wdata  output  32  full-word write data.
REQ-016 SHALL have port: mem_rdata  input  32  asynchronous read data of word at mem_addr.

Function
REQ-017 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-018 SHALL latch req_we, req_funct3, req_addr, req_wdata on acceptance (cycle T); inputs ignored otherwise.
REQ-019 SHALL sequence loads IDLE->RD->RESP: resp_valid at T+2.
REQ-020 SHALL sequence SW IDLE->WR->RESP: MemRW=1 at T+1, resp_valid at T+2.
REQ-021 SHALL sequence SB/SH IDLE->RD->WR->RESP: old word captured end of T+1, merged word written T+2, resp_valid at T+3.
REQ-022 SHALL drive mem_addr=(latched addr - MEM_BASE) with bits [1:0] cleared in RD and WR; 0 elsewhere.
REQ-023 SHALL assert MemRW only in WR, exactly one cycle per store; never for loads or errors.
REQ-024 SHALL select load byte by addr[1:0] and halfword by addr[1]; B/H sign-extend, BU/HU zero-extend, W pass through.
REQ-025 SHALL merge stores: SB replaces byte lane addr[1:0] with wdata[7:0], SH replaces half addr[1] with wdata[15:0], other bytes from captured word.
REQ-026 SHALL treat funct3 011/110/111, and store funct3 100/101, as illegal: IDLE->RESP, resp_err=1, no memory access, resp_valid at T+1.
REQ-027 SHALL hold resp_valid for exactly one cycle, then return to IDLE; no backpressure on response.
REQ-028 SHALL register resp_rdata and resp_err; both 0 whenever resp_valid=0.

Reset
REQ-029 SHALL on rst at any posedge force IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, MemRW=0, mem_addr=0, mem_wdata=0.
REQ-030 SHALL drop an in-flight operation on reset with no response; if reset hits RD of a sub-word store, no write occurs.
REQ-031 SHALL ignore req_valid in the reset cycle.

Configuration
REQ-032 SHALL, with MISALIGN_TRAP_EN defined, treat H/HU/SH with addr[0]=1 and W/SW with addr[1:0]!=00 as errors per REQ-026 timing.
REQ-033 SHALL, without MISALIGN_TRAP_EN, never flag misalignment: low address bits beyond the access width are ignored (halfword uses addr[1], word uses aligned word), and resp_err arises only from REQ-026.

Verification
REQ-034 SHALL test SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> one MemRW pulse at mem_addr 0x10, load resp_rdata 0xDEADBEEF at T+2.
REQ-035 SHALL test SB 0x13 data 0x000000A5 over word 0x11223344 -> written word 0xA5223344, then LB 0x13 -> 0xFFFFFFA5, LBU 0x13 -> 0x000000A5.
REQ-036 SHALL test SH 0x22 data 0x8001 over 0 -> word 0x80010000; LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001.
REQ-037 SHALL test LW 0x06 -> with MISALIGN_TRAP_EN resp_err=1 at T+1, no memory access; without it resp_rdata = word at 0x04.
REQ-038 SHALL test rst asserted during RD of SB 0x01 -> no MemRW pulse, no resp_valid, req_ready=1 next cycle, memory unchanged.
REQ-039 SHALL test back-to-back requests with req_valid held high -> second accepted only in the cycle after RESP; illegal funct3 111 -> resp_err=1 at T+1.
